// File: rtl/seg7_decode_if.sv
// Segment-bus decoder interface: raw segment input plus the decoded
// report and its valid/ready handshake.
interface seg7_decode_if;
    logic [6:0] segIn;
    logic       outReady;
    logic       outValid;
    logic [3:0] dataOut;
    logic       blank;
    logic       invalid;

    // Decoder side: consumes segments and ready, produces the report.
    modport master (
        input  segIn,
        input  outReady,
        output outValid,
        output dataOut,
        output blank,
        output invalid
    );

    // Driver/consumer side.
    modport slave (
        output segIn,
        output outReady,
        input  outValid,
        input  dataOut,
        input  blank,
        input  invalid
    );
endinterface

// File: rtl/seg7_decode.sv
// Seven-segment bus decoder: debounces an active-low segment pattern,
// decodes it to a hex digit and reports each new stable pattern once
// through a valid/ready handshake.
module seg7_decode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    seg7_decode_if.master bus
);

    typedef enum logic {SETTLE, HOLD} state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    state_t     state, stateNxt;
    logic [6:0] sampleReg;
    logic [7:0] stableCnt;
    logic [6:0] reportedPat, reportedPatNxt;
    logic       reportedVld, reportedVldNxt;
    logic [6:0] latchedPat, latchedPatNxt;
    logic       outValidQ, outValidNxt;
    logic [3:0] dataQ, dataNxt;
    logic       blankQ, blankNxt;
    logic       invalidQ, invalidNxt;
    logic [3:0] decVal;
    logic       decBlank, decInvalid;

    // Input sampling and stability counter; run in every state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sampleReg <= 7'h7F;
            stableCnt <= '0;
        end else begin
            sampleReg <= bus.segIn;
            if (bus.segIn != sampleReg)
                stableCnt <= '0;
            else if (stableCnt != STABLE_MAX)
                stableCnt <= stableCnt + 8'd1;
        end
    end

    // Segment pattern (gfedcba, active low) to hex digit / blank / invalid.
    always_comb begin
        decVal     = '0;
        decBlank   = 1'b0;
        decInvalid = 1'b0;
        case (sampleReg)
            7'b1000000: decVal = 4'h0;
            7'b1111001: decVal = 4'h1;
            7'b0100100: decVal = 4'h2;
            7'b0110000: decVal = 4'h3;
            7'b0011001: decVal = 4'h4;
            7'b0010010: decVal = 4'h5;
            7'b0000010: decVal = 4'h6;
            7'b1111000: decVal = 4'h7;
            7'b0000000: decVal = 4'h8;
            7'b0011000: decVal = 4'h9;
            7'b0001000: decVal = 4'hA;
            7'b0000011: decVal = 4'hB;
            7'b1000110: decVal = 4'hC;
            7'b0100001: decVal = 4'hD;
            7'b0000110: decVal = 4'hE;
            7'b0001110: decVal = 4'hF;
            7'b1111111: decBlank = 1'b1;
            default:    decInvalid = 1'b1;
        endcase
    end

    // Report FSM state and held output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= SETTLE;
            reportedPat <= 7'h7F;
            reportedVld <= 1'b0;
            latchedPat  <= 7'h7F;
            outValidQ   <= 1'b0;
            dataQ       <= '0;
            blankQ      <= 1'b0;
            invalidQ    <= 1'b0;
        end else begin
            state       <= stateNxt;
            reportedPat <= reportedPatNxt;
            reportedVld <= reportedVldNxt;
            latchedPat  <= latchedPatNxt;
            outValidQ   <= outValidNxt;
            dataQ       <= dataNxt;
            blankQ      <= blankNxt;
            invalidQ    <= invalidNxt;
        end
    end

    // Next-state: report a new stable pattern, then hold it until accepted.
    always_comb begin
        stateNxt       = state;
        reportedPatNxt = reportedPat;
        reportedVldNxt = reportedVld;
        latchedPatNxt  = latchedPat;
        outValidNxt    = outValidQ;
        dataNxt        = dataQ;
        blankNxt       = blankQ;
        invalidNxt     = invalidQ;
        case (state)
            SETTLE: begin
                if (stableCnt == STABLE_MAX &&
                    (!reportedVld || sampleReg != reportedPat)) begin
                    latchedPatNxt = sampleReg;
                    dataNxt       = decVal;
                    blankNxt      = decBlank;
                    invalidNxt    = decInvalid;
                    outValidNxt   = 1'b1;
                    stateNxt      = HOLD;
                end
            end
            HOLD: begin
                if (outValidQ && bus.outReady) begin
                    outValidNxt    = 1'b0;
                    reportedPatNxt = latchedPat;
                    reportedVldNxt = 1'b1;
                    stateNxt       = SETTLE;
                end
            end
            default: stateNxt = SETTLE;
        endcase
    end

    assign bus.outValid = outValidQ;
    assign bus.dataOut  = dataQ;
    assign bus.blank    = blankQ;
    assign bus.invalid  = invalidQ;

endmodule

// File: tb/tb_seg7_decode.sv
// Directed testbench for seg7_decode with hand-computed expectations.
module tb_seg7_decode;

    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned nChecks = 0;
    int unsigned nPass = 0;

    seg7_decode_if bus ();

    seg7_decode #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One rising edge, then settle so outputs can be sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until outValid rises or the limit expires; n = edges taken.
    task automatic wait_report(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.outValid && n < limit);
    endtask

    int unsigned lat;
    int unsigned bad;

    initial begin
        reset_n      = 1'b0;
        bus.segIn    = 7'h7F;
        bus.outReady = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.outValid), 32'd0);
        check("rst_data",  32'(bus.dataOut),  32'd0);
        check("rst_blank", 32'(bus.blank),    32'd0);
        check("rst_inv",   32'(bus.invalid),  32'd0);

        // Blank pattern already in sampleReg after reset: report on 5th edge.
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.outValid) bad++;
        end
        check("blank_early", 32'(bad), 32'd0);
        tick();
        check("blank_valid", 32'(bus.outValid), 32'd1);
        check("blank_flag",  32'(bus.blank),    32'd1);
        check("blank_data",  32'(bus.dataOut),  32'd0);
        check("blank_inv",   32'(bus.invalid),  32'd0);
        tick();
        check("blank_hs", 32'(bus.outValid), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.outValid) bad++;
        end
        check("blank_once", 32'(bad), 32'd0);

        // Digit 2: captured on first edge, report S+1 edges later.
        bus.segIn = 7'b0100100;
        wait_report(20, lat);
        check("two_lat",   32'(lat), 32'(S + 2));
        check("two_data",  32'(bus.dataOut), 32'h2);
        check("two_blank", 32'(bus.blank),   32'd0);
        check("two_inv",   32'(bus.invalid), 32'd0);

        // All segments on decodes as 8.
        bus.segIn = 7'b0000000;
        wait_report(20, lat);
        check("eight_lat",   32'(lat), 32'(S + 2));
        check("eight_data",  32'(bus.dataOut), 32'h8);
        check("eight_blank", 32'(bus.blank),   32'd0);
        check("eight_inv",   32'(bus.invalid), 32'd0);

        // Back to 2, then a short glitch to 3 and back: nothing reported.
        bus.segIn = 7'b0100100;
        wait_report(20, lat);
        check("two_again", 32'(bus.dataOut), 32'h2);
        tick();
        check("two_hs", 32'(bus.outValid), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        bad = 0;
        bus.segIn = 7'b0110000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.outValid) bad++;
        end
        bus.segIn = 7'b0100100;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.outValid) bad++;
        end
        check("glitch_none", 32'(bad), 32'd0);

        // Report A held without ready while input moves to B.
        bus.outReady = 1'b0;
        bus.segIn    = 7'b0001000;
        wait_report(20, lat);
        check("a_lat",  32'(lat), 32'(S + 2));
        check("a_data", 32'(bus.dataOut), 32'hA);
        bus.segIn = 7'b0000011;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.outValid || bus.dataOut != 4'hA) bad++;
        end
        check("a_hold", 32'(bad), 32'd0);
        bus.outReady = 1'b1;
        tick();
        check("a_hs", 32'(bus.outValid), 32'd0);
        tick();
        check("b_valid", 32'(bus.outValid), 32'd1);
        check("b_data",  32'(bus.dataOut),  32'hB);
        tick();

        // Pattern outside the table.
        bus.segIn = 7'b1010101;
        wait_report(20, lat);
        check("inv_lat",   32'(lat), 32'(S + 2));
        check("inv_flag",  32'(bus.invalid), 32'd1);
        check("inv_data",  32'(bus.dataOut), 32'd0);
        check("inv_blank", 32'(bus.blank),   32'd0);
        tick();

        // Reset during HOLD drops the pending report; the same pattern is
        // re-captured on the first edge sampling reset_n high and reported
        // S+1 edges after that.
        bus.outReady = 1'b0;
        bus.segIn    = 7'b0011001;
        wait_report(20, lat);
        check("four_data", 32'(bus.dataOut), 32'h4);
        reset_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(bus.outValid), 32'd0);
        check("mid_rst_data",  32'(bus.dataOut),  32'd0);
        reset_n = 1'b1;
        wait_report(20, lat);
        check("rerep_lat",  32'(lat), 32'(S + 2));
        check("rerep_data", 32'(bus.dataOut), 32'h4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
